uart_reg_master: RTL and testbench

//  Host/initiator side of the UART register protocol: turns single register read/write

---
 rtl/uart_reg_master.sv | 215 +++++++++++++++++++++
 tb/tb_uart_reg_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_master.sv
// Initiator side of the UART register protocol: serialises one register read/write
// into "S<idx>W<B0..Bn-1>" / "S<idx>R" bytes and collects the n-byte read reply.
module uart_reg_master #(
    parameter int NUM_BYTES_PER_REG = 4,
    parameter int TIMEOUT_CYCLES    = 1000000
) (
    input  logic                           clock,
    input  logic                           srst,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic                           cmd_write,
    input  logic [7:0]                     cmd_index,
    input  logic [8*NUM_BYTES_PER_REG-1:0] cmd_wdata,
    output logic                           rsp_valid,
    output logic                           rsp_error,
    output logic [8*NUM_BYTES_PER_REG-1:0] rsp_rdata,
    output logic [7:0]                     uart_tx_value,
    output logic                           uart_tx_value_write,
    input  logic                           uart_tx_value_done,
    input  logic [7:0]                     uart_rx_value,
    input  logic                           uart_rx_value_ready
);

    localparam int NB    = NUM_BYTES_PER_REG;
    localparam int DW    = 8 * NB;
    localparam int POS_W = $clog2(NB + 3);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [POS_W-1:0] POS_LAST_READ  = POS_W'(2);
    localparam logic [POS_W-1:0] POS_LAST_WRITE = POS_W'(2 + NB);
    localparam logic [POS_W-1:0] RX_LAST        = POS_W'(NB - 1);
    localparam logic [TMR_W-1:0] TMR_START      = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST       = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_WRITE = 3'd1,
        ST_TX_WAIT  = 3'd2,
        ST_RX_WAIT  = 3'd3,
        ST_RESP     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  tx_pos_q, tx_pos_d;
    logic [POS_W-1:0]  rx_pos_q, rx_pos_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              cmd_write_q, cmd_write_d;
    logic [7:0]        cmd_index_q, cmd_index_d;
    logic [DW-1:0]     cmd_wdata_q, cmd_wdata_d;
    logic [DW-1:0]     rbuf_q, rbuf_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_error_q, rsp_error_d;
    logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [7:0]        tx_value_q, tx_value_d;
    logic              tx_write_q, tx_write_d;

    logic [POS_W-1:0]  tx_pos_inc_s;
    logic [POS_W-1:0]  rx_pos_inc_s;
    logic [TMR_W-1:0]  timer_inc_s;

    assign tx_pos_inc_s = tx_pos_q + POS_W'(1);
    assign rx_pos_inc_s = rx_pos_q + POS_W'(1);
    assign timer_inc_s  = timer_q + TMR_W'(1);

    // Wire byte at position pos: 'S', index, 'W'/'R', then write data LSB first.
    function automatic logic [7:0] tx_byte(
        input logic [POS_W-1:0] pos,
        input logic             wr,
        input logic [7:0]       idx,
        input logic [DW-1:0]    wdata
    );
        logic [7:0] b;
        b = 8'h00;
        case (pos)
            POS_W'(0): b = 8'h53;
            POS_W'(1): b = idx;
            POS_W'(2): b = wr ? 8'h57 : 8'h52;
            default: begin
                for (int k = 0; k < NB; k++) begin
                    b = (pos == POS_W'(k + 3)) ? wdata[8*k +: 8] : b;
                end
            end
        endcase
        return b;
    endfunction

    // Next-state and registered-output computation for the transaction FSM.
    always_comb begin
        state_d     = state_q;
        tx_pos_d    = tx_pos_q;
        rx_pos_d    = rx_pos_q;
        timer_d     = timer_q;
        cmd_write_d = cmd_write_q;
        cmd_index_d = cmd_index_q;
        cmd_wdata_d = cmd_wdata_q;
        rbuf_d      = rbuf_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_error_d = 1'b0;
        rsp_rdata_d = '0;
        tx_value_d  = tx_value_q;
        tx_write_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_write_d = cmd_write;
                    cmd_index_d = cmd_index;
                    cmd_wdata_d = cmd_wdata;
                    tx_pos_d    = '0;
                    tx_value_d  = 8'h53;
                    tx_write_d  = 1'b1;
                    state_d     = ST_TX_WRITE;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            ST_TX_WRITE: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (uart_tx_value_done) begin
                    if (cmd_write_q && (tx_pos_q == POS_LAST_WRITE)) begin
                        rsp_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end else if (!cmd_write_q && (tx_pos_q == POS_LAST_READ)) begin
                        rx_pos_d = '0;
                        timer_d  = TMR_START;
                        rbuf_d   = '0;
                        state_d  = ST_RX_WAIT;
                    end else begin
                        tx_pos_d   = tx_pos_inc_s;
                        tx_value_d = tx_byte(tx_pos_inc_s, cmd_write_q, cmd_index_q, cmd_wdata_q);
                        tx_write_d = 1'b1;
                        state_d    = ST_TX_WRITE;
                    end
                end else begin
                    state_d = ST_TX_WAIT;
                end
            end
            ST_RX_WAIT: begin
                // A byte arriving on the expiry cycle takes priority over the timeout.
                if (uart_rx_value_ready) begin
                    for (int k = 0; k < NB; k++) begin
                        rbuf_d[8*k +: 8] = (rx_pos_q == POS_W'(k)) ? uart_rx_value : rbuf_q[8*k +: 8];
                    end
                    if (rx_pos_q == RX_LAST) begin
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = rbuf_d;
                        state_d     = ST_RESP;
                    end else begin
                        rx_pos_d = rx_pos_inc_s;
                        timer_d  = TMR_START;
                    end
                end else if (timer_q == TMR_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    timer_d = timer_inc_s;
                end
            end
            ST_RESP: begin
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            tx_pos_q    <= '0;
            rx_pos_q    <= '0;
            timer_q     <= '0;
            cmd_write_q <= 1'b0;
            cmd_index_q <= 8'h00;
            cmd_wdata_q <= '0;
            rbuf_q      <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
            tx_value_q  <= 8'h00;
            tx_write_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_pos_q    <= tx_pos_d;
            rx_pos_q    <= rx_pos_d;
            timer_q     <= timer_d;
            cmd_write_q <= cmd_write_d;
            cmd_index_q <= cmd_index_d;
            cmd_wdata_q <= cmd_wdata_d;
            rbuf_q      <= rbuf_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_error_q <= rsp_error_d;
            rsp_rdata_q <= rsp_rdata_d;
            tx_value_q  <= tx_value_d;
            tx_write_q  <= tx_write_d;
        end
    end

    assign cmd_ready           = cmd_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_error           = rsp_error_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign uart_tx_value       = tx_value_q;
    assign uart_tx_value_write = tx_write_q;

endmodule

// File: tb/tb_uart_reg_master.sv
// Directed bench for uart_reg_master: vector table of single transactions plus
// hand-written sequences for mid-transaction reset and held cmd_valid.
module tb_uart_reg_master;

    localparam int NB = 4;
    localparam int TC = 50;

    logic              clock = 1'b0;
    logic              srst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [7:0]        cmd_index;
    logic [8*NB-1:0]   cmd_wdata;
    logic              rsp_valid;
    logic              rsp_error;
    logic [8*NB-1:0]   rsp_rdata;
    logic [7:0]        uart_tx_value;
    logic              uart_tx_value_write;
    logic              uart_tx_value_done;
    logic [7:0]        uart_rx_value;
    logic              uart_rx_value_ready;

    int checks   = 0;
    int failures = 0;

    uart_reg_master #(
        .NUM_BYTES_PER_REG (NB),
        .TIMEOUT_CYCLES    (TC)
    ) dut (
        .clock               (clock),
        .srst                (srst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_write           (cmd_write),
        .cmd_index           (cmd_index),
        .cmd_wdata           (cmd_wdata),
        .rsp_valid           (rsp_valid),
        .rsp_error           (rsp_error),
        .rsp_rdata           (rsp_rdata),
        .uart_tx_value       (uart_tx_value),
        .uart_tx_value_write (uart_tx_value_write),
        .uart_tx_value_done  (uart_tx_value_done),
        .uart_rx_value       (uart_rx_value),
        .uart_rx_value_ready (uart_rx_value_ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        wr;
        logic [7:0]  idx;
        logic [31:0] wd;
        int          nreply;
        logic [31:0] reply;
        logic        stray;
        int          exp_n;
        logic [55:0] exp_bytes;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    // results of the most recent run_txn
    logic [55:0] tx_log;
    int          n_tx;
    logic        got_rsp;
    logic        got_err;
    logic [31:0] got_rdata;
    int          lat;
    int          first_wr;
    logic        b2b_seen;
    logic        ready_busy;
    logic        hold_err;
    logic        post_ready;
    logic        post_valid;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (cmd_ready !== 1'b1 && guard < 20) begin
            @(negedge clock);
            guard++;
        end
    endtask

    // One command with a TX engine model (done ~10 cycles after each write pulse)
    // and an RX model that replies nreply bytes after the 'R' byte completes.
    task automatic run_txn(input logic wr, input logic [7:0] idx, input logic [31:0] wd,
                           input int nreply, input logic [31:0] reply, input logic stray);
        int   done_cnt, rx_cnt, ndone, nsent, last_evt;
        logic prev_wr, rx_on;
        logic [7:0] last_byte;
        tx_log = '0; n_tx = 0; got_rsp = 1'b0; got_err = 1'b0; got_rdata = '0;
        lat = -1; first_wr = -1; b2b_seen = 1'b0; ready_busy = 1'b0; hold_err = 1'b0;
        done_cnt = 0; rx_cnt = 0; ndone = 0; nsent = 0; last_evt = 0;
        prev_wr = 1'b0; rx_on = 1'b0; last_byte = 8'h00;
        wait_ready();
        if (stray) begin
            uart_rx_value_ready = 1'b1;
            uart_rx_value       = 8'h3C;
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_index = idx; cmd_wdata = wd;
        @(negedge clock);
        cmd_valid = 1'b0; cmd_write = ~wr; cmd_index = ~idx; cmd_wdata = ~wd;
        uart_rx_value_ready = 1'b0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (uart_tx_value_write === 1'b1) begin
                if (prev_wr) b2b_seen = 1'b1;
                if (first_wr < 0) first_wr = cyc;
                if (n_tx < 7) tx_log[8*n_tx +: 8] = uart_tx_value;
                last_byte = uart_tx_value;
                n_tx++;
                done_cnt = 10;
            end else if (done_cnt > 0 && uart_tx_value !== last_byte) begin
                hold_err = 1'b1;
            end
            prev_wr = (uart_tx_value_write === 1'b1);
            if (cmd_ready === 1'b1) ready_busy = 1'b1;
            if (rsp_valid === 1'b1) begin
                got_rsp = 1'b1; got_err = rsp_error; got_rdata = rsp_rdata;
                lat = cyc - last_evt;
                break;
            end
            uart_tx_value_done  = 1'b0;
            uart_rx_value_ready = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    uart_tx_value_done = 1'b1;
                    ndone++;
                    last_evt = cyc;
                    if (!wr && ndone == 3) begin
                        rx_on  = 1'b1;
                        rx_cnt = 4;
                    end
                end else if (stray && done_cnt == 5) begin
                    uart_rx_value_ready = 1'b1;
                    uart_rx_value       = 8'hA5;
                end
            end else if (rx_on) begin
                if (stray && rx_cnt == 2) uart_tx_value_done = 1'b1;
                if (rx_cnt > 0) begin
                    rx_cnt--;
                end else if (nsent < nreply) begin
                    uart_rx_value_ready = 1'b1;
                    uart_rx_value       = reply[8*nsent +: 8];
                    nsent++;
                    last_evt = cyc;
                    rx_cnt   = 3;
                end
            end
        end
        uart_tx_value_done  = 1'b0;
        uart_rx_value_ready = 1'b0;
        @(negedge clock);
        post_ready = cmd_ready;
        post_valid = rsp_valid;
    endtask

    task automatic check_txn(input string tag, input int exp_n, input logic [55:0] exp_bytes,
                             input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        check({tag, "_ntx"},       n_tx, exp_n);
        check({tag, "_bytes"},     tx_log, exp_bytes);
        check({tag, "_rsp_seen"},  got_rsp, 1'b1);
        check({tag, "_rsp_error"}, got_err, exp_err);
        check({tag, "_rsp_rdata"}, got_rdata, exp_rdata);
        check({tag, "_rsp_lat"},   lat, exp_lat);
        check({tag, "_first_wr"},  first_wr, 1);
        check({tag, "_b2b_write"}, b2b_seen, 1'b0);
        check({tag, "_busy_ready"}, ready_busy, 1'b0);
        check({tag, "_tx_hold"},   hold_err, 1'b0);
        check({tag, "_post_ready"}, post_ready, 1'b1);
        check({tag, "_post_valid"}, post_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int npulse, dcnt, nwr, nrsp, nacc, rsp1_cyc, acc1_cyc;
        logic [111:0] log2;
        logic [31:0]  acc[2];

        vecs[0] = '{1'b1, 8'h02, 32'hDEADBEEF, 0, 32'h0,        1'b0, 7, 56'hDEADBEEF570253, 1'b0, 32'h0,        1};
        vecs[1] = '{1'b0, 8'h05, 32'h0,        4, 32'h12345678, 1'b0, 3, 56'h00000000520553, 1'b0, 32'h12345678, 1};
        vecs[2] = '{1'b0, 8'h07, 32'h0,        2, 32'h0000BBAA, 1'b0, 3, 56'h00000000520753, 1'b1, 32'h0,        TC};
        vecs[3] = '{1'b0, 8'h09, 32'h0,        4, 32'hCAFEF00D, 1'b1, 3, 56'h00000000520953, 1'b0, 32'hCAFEF00D, 1};
        vecs[4] = '{1'b1, 8'hFF, 32'h00000001, 0, 32'h0,        1'b1, 7, 56'h0000000157FF53, 1'b0, 32'h0,        1};
        vecs[5] = '{1'b0, 8'h00, 32'h0,        0, 32'h0,        1'b0, 3, 56'h00000000520053, 1'b1, 32'h0,        TC};
        vecs[6] = '{1'b0, 8'h80, 32'h0,        4, 32'hA1B2C3D4, 1'b0, 3, 56'h00000000528053, 1'b0, 32'hA1B2C3D4, 1};

        srst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = 8'h00; cmd_wdata = '0;
        uart_tx_value_done = 1'b0; uart_rx_value = 8'h00; uart_rx_value_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_cmd_ready", cmd_ready, 1'b0);
        check("reset_outputs", {rsp_valid, rsp_error, rsp_rdata, uart_tx_value, uart_tx_value_write}, '0);
        srst = 1'b0;
        @(negedge clock);
        check("reset_release_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].wr, vecs[i].idx, vecs[i].wd, vecs[i].nreply, vecs[i].reply, vecs[i].stray);
            check_txn($sformatf("v%0d", i), vecs[i].exp_n, vecs[i].exp_bytes,
                      vecs[i].exp_err, vecs[i].exp_rdata, vecs[i].exp_lat);
        end

        // reset while waiting for the index byte's done
        wait_ready();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_index = 8'h44; cmd_wdata = 32'h55667788;
        @(negedge clock);
        cmd_valid = 1'b0;
        npulse = 0; dcnt = 0;
        for (int c = 0; c < 60 && npulse < 2; c++) begin
            if (c > 0) @(negedge clock);
            uart_tx_value_done = 1'b0;
            if (uart_tx_value_write === 1'b1) begin
                npulse++;
                dcnt = 4;
            end else if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) uart_tx_value_done = 1'b1;
            end
        end
        uart_tx_value_done = 1'b0;
        check("mid_reset_pulses_before", npulse, 2);
        repeat (2) @(negedge clock);
        srst = 1'b1;
        @(negedge clock);
        check("mid_reset_outputs", {cmd_ready, rsp_valid, rsp_error, rsp_rdata, uart_tx_value, uart_tx_value_write}, '0);
        srst = 1'b0;
        uart_tx_value_done = 1'b1;
        nwr = 0; nrsp = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            uart_tx_value_done = 1'b0;
            if (uart_tx_value_write === 1'b1) nwr++;
            if (rsp_valid === 1'b1) nrsp++;
        end
        check("mid_reset_no_write", nwr, 0);
        check("mid_reset_no_rsp", nrsp, 0);
        run_txn(1'b1, 8'h44, 32'h55667788, 0, 32'h0, 1'b0);
        check_txn("after_reset", 7, 56'h55667788574453, 1'b0, 32'h0, 1);

        // cmd_valid held high with wdata changing every cycle
        wait_ready();
        log2 = '0; nwr = 0; nrsp = 0; nacc = 0; dcnt = 0; rsp1_cyc = -1; acc1_cyc = -100;
        acc[0] = '0; acc[1] = '0;
        cmd_write = 1'b1; cmd_index = 8'h10;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clock);
            if (uart_tx_value_write === 1'b1) begin
                if (nwr < 14) log2[8*nwr +: 8] = uart_tx_value;
                nwr++;
                dcnt = 3;
            end
            if (rsp_valid === 1'b1) begin
                nrsp++;
                if (nrsp == 1) rsp1_cyc = cyc;
            end
            uart_tx_value_done = 1'b0;
            if (dcnt > 0) begin
                dcnt--;
                if (dcnt == 0) uart_tx_value_done = 1'b1;
            end
            cmd_valid = 1'b1;
            cmd_wdata = 32'h10000000 + cyc * 32'h00010203;
            if (cmd_ready === 1'b1) begin
                if (nacc < 2) acc[nacc] = cmd_wdata;
                if (nacc == 1) acc1_cyc = cyc;
                nacc++;
            end
            if (nrsp == 2) begin
                cmd_valid = 1'b0;
                break;
            end
        end
        cmd_valid = 1'b0;
        uart_tx_value_done = 1'b0;
        check("hold_accepts", nacc, 2);
        check("hold_rsps", nrsp, 2);
        check("hold_write_pulses", nwr, 14);
        check("hold_txn1_bytes", log2[55:0], {acc[0], 8'h57, 8'h10, 8'h53});
        check("hold_txn2_bytes", log2[111:56], {acc[1], 8'h57, 8'h10, 8'h53});
        check("hold_idle_gap", acc1_cyc - rsp1_cyc, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
